// File: rtl/light_hash_stream_if.sv
// Character-in / digest-out handshake bundle for light_hash_stream.
// master = character source and digest consumer; slave = the hash block.
interface light_hash_stream_if;
    logic [7:0] msg_char;
    logic       msg_valid;
    logic       msg_last;
    logic       msg_ready;
    logic [7:0] dig_char;
    logic       dig_valid;
    logic       dig_last;
    logic       dig_ready;
    logic       err_invalid_char;

    modport master (
        output msg_char, msg_valid, msg_last, dig_ready,
        input  msg_ready, dig_char, dig_valid, dig_last, err_invalid_char
    );

    modport slave (
        input  msg_char, msg_valid, msg_last, dig_ready,
        output msg_ready, dig_char, dig_valid, dig_last, err_invalid_char
    );
endinterface

// File: rtl/light_hash_stream.sv
// Streaming light hash: absorbs printable chars, ROUNDS S-box rounds per char, streams an N-byte digest.
// Optional macro LH_LENGTH_PAD_EN adds a final round sequence keyed by the absorbed-character count.
module light_hash_stream #(
    parameter int DIGEST_BYTES = 8,
    parameter int ROUNDS       = 32
) (
    input  logic               clk,
    input  logic               rst,
    light_hash_stream_if.slave lh
);
    // IDLE: accept a char | ROUND: one full round per cycle | OUT: stream digest bytes
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_OUT   = 2'd2;

    localparam int              KW     = (DIGEST_BYTES > 1) ? $clog2(DIGEST_BYTES) : 1;
    localparam logic [KW-1:0]   K_LAST = KW'(DIGEST_BYTES - 1);
    localparam logic [7:0]      R_LAST = 8'(ROUNDS - 1);

    localparam logic [7:0] IV8 [8] = '{8'h34, 8'h55, 8'h0F, 8'h14, 8'hDA, 8'hC0, 8'h2B, 8'hEE};

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    logic [1:0]    state_q, state_d;
    logic [7:0]    h_q   [DIGEST_BYTES];
    logic [7:0]    h_d   [DIGEST_BYTES];
    logic [7:0]    h_rnd [DIGEST_BYTES];
    logic [7:0]    m_q, m_d;
    logic          last_q, last_d;
    logic [7:0]    cnt_q, cnt_d;
    logic [KW-1:0] k_q, k_d;
    logic          msg_ready_q, msg_ready_d;
    logic [7:0]    dig_char_q, dig_char_d;
    logic          dig_valid_q, dig_valid_d;
    logic          dig_last_q, dig_last_d;
    logic          err_q, err_d;

    logic accept;
    logic char_ok;
    logic finalise;
    logic start_out;
    logic load_iv;
    logic pad_phase;

`ifdef LH_LENGTH_PAD_EN
    logic [7:0] len_q, len_d;
    logic       pad_q, pad_d;
    assign pad_phase = pad_q;
`else
    assign pad_phase = 1'b0;
`endif

    assign char_ok = (lh.msg_char >= 8'h20) && (lh.msg_char <= 8'h7E);
    assign accept  = (state_q == S_IDLE) && msg_ready_q && lh.msg_valid;

    // Bytes are updated in place: later bytes see values already rewritten this round.
    always_comb begin
        logic [7:0] t [DIGEST_BYTES];
        for (int i = 0; i < DIGEST_BYTES; i++) begin
            t[i] = h_q[i];
        end
        for (int i = 0; i < DIGEST_BYTES; i++) begin
            t[i] = SBOX[8'((t[(i + 2) % DIGEST_BYTES] ^ m_q) << (i % 8))];
        end
        for (int i = 0; i < DIGEST_BYTES; i++) begin
            h_rnd[i] = t[i];
        end
    end

    always_comb begin
        state_d     = state_q;
        for (int i = 0; i < DIGEST_BYTES; i++) begin
            h_d[i] = h_q[i];
        end
        m_d         = m_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        k_d         = k_q;
        dig_char_d  = dig_char_q;
        dig_valid_d = dig_valid_q;
        dig_last_d  = dig_last_q;
        err_d       = 1'b0;
        finalise    = 1'b0;
        start_out   = 1'b0;
        load_iv     = 1'b0;
`ifdef LH_LENGTH_PAD_EN
        len_d       = len_q;
        pad_d       = pad_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (char_ok) begin
                        m_d     = lh.msg_char;
                        last_d  = lh.msg_last;
                        cnt_d   = '0;
                        state_d = S_ROUND;
`ifdef LH_LENGTH_PAD_EN
                        len_d   = len_q + 8'd1;
`endif
                    end else begin
                        err_d    = 1'b1;
                        finalise = lh.msg_last;
                    end
                end
            end
            S_ROUND: begin
                for (int i = 0; i < DIGEST_BYTES; i++) begin
                    h_d[i] = h_rnd[i];
                end
                cnt_d = cnt_q + 8'd1;
                if (cnt_q == R_LAST) begin
                    if (!last_q) begin
                        state_d = S_IDLE;
                    end else if (pad_phase) begin
                        start_out = 1'b1;
                    end else begin
                        finalise = 1'b1;
                    end
                end
            end
            S_OUT: begin
                if (lh.dig_ready) begin
                    if (k_q == K_LAST) begin
                        load_iv     = 1'b1;
                        state_d     = S_IDLE;
                        k_d         = '0;
                        dig_valid_d = 1'b0;
                        dig_char_d  = 8'h00;
                        dig_last_d  = 1'b0;
                    end else begin
                        k_d        = k_q + 1'b1;
                        dig_char_d = h_q[k_d];
                        dig_last_d = (k_d == K_LAST);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef LH_LENGTH_PAD_EN
        // Finalisation re-enters ROUND once more, keyed by the character count.
        if (finalise) begin
            state_d = S_ROUND;
            m_d     = len_q;
            cnt_d   = '0;
            last_d  = 1'b1;
            pad_d   = 1'b1;
        end
`else
        if (finalise) begin
            start_out = 1'b1;
        end
`endif

        if (start_out) begin
            state_d     = S_OUT;
            k_d         = '0;
            dig_valid_d = 1'b1;
            dig_char_d  = h_d[0];
            dig_last_d  = (K_LAST == '0);
        end

        if (load_iv) begin
            for (int i = 0; i < DIGEST_BYTES; i++) begin
                h_d[i] = IV8[i % 8];
            end
`ifdef LH_LENGTH_PAD_EN
            len_d = 8'd0;
            pad_d = 1'b0;
`endif
        end

        msg_ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            for (int i = 0; i < DIGEST_BYTES; i++) begin
                h_q[i] <= IV8[i % 8];
            end
            m_q         <= 8'h00;
            last_q      <= 1'b0;
            cnt_q       <= 8'd0;
            k_q         <= '0;
            msg_ready_q <= 1'b0;
            dig_char_q  <= 8'h00;
            dig_valid_q <= 1'b0;
            dig_last_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            for (int i = 0; i < DIGEST_BYTES; i++) begin
                h_q[i] <= h_d[i];
            end
            m_q         <= m_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            k_q         <= k_d;
            msg_ready_q <= msg_ready_d;
            dig_char_q  <= dig_char_d;
            dig_valid_q <= dig_valid_d;
            dig_last_q  <= dig_last_d;
            err_q       <= err_d;
        end
    end

`ifdef LH_LENGTH_PAD_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q <= 8'd0;
            pad_q <= 1'b0;
        end else begin
            len_q <= len_d;
            pad_q <= pad_d;
        end
    end
`endif

    assign lh.msg_ready        = msg_ready_q;
    assign lh.dig_char         = dig_char_q;
    assign lh.dig_valid        = dig_valid_q;
    assign lh.dig_last         = dig_last_q;
    assign lh.err_invalid_char = err_q;
endmodule

// File: tb/tb_light_hash_stream.sv
// Scoreboard bench for light_hash_stream: randomized messages against a GF(2^8)-derived reference model.
`timescale 1ns/1ps
module tb_light_hash_stream;
    localparam int NA = 8;
    localparam int RA = 32;
    localparam int NB = 4;
    localparam int RB = 1;
`ifdef LH_LENGTH_PAD_EN
    localparam int PAD = 1;
`else
    localparam int PAD = 0;
`endif
    localparam logic [7:0] IV_T [8] = '{8'h34, 8'h55, 8'h0F, 8'h14, 8'hDA, 8'hC0, 8'h2B, 8'hEE};

    typedef logic [7:0] bq_t [$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [7:0] sbox_m [256];
    logic [7:0] exp_q [$];
    bit         exp_last_q [$];
    bq_t        cur_msg;
    int         err_exp = 0;
    int         err_seen = 0;
    int         out_idx = 0;
    int         hold_left = 0;
    int         hold_cycles = 0;
    int         bp_mode = 0;
    bit         held = 1'b0;
    logic [7:0] held_char = 8'h00;

    light_hash_stream_if a_if();
    light_hash_stream_if b_if();

    light_hash_stream #(.DIGEST_BYTES(NA), .ROUNDS(RA)) dut_a (.clk(clk), .rst(rst), .lh(a_if));
    light_hash_stream #(.DIGEST_BYTES(NB), .ROUNDS(RB)) dut_b (.clk(clk), .rst(rst), .lh(b_if));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: bound expired or unexpected event at %0t", name, $time);
    endtask

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
        logic [7:0] r = v;
        for (int i = 0; i < k; i++) r = {r[6:0], r[7]};
        return r;
    endfunction

    // S-box from its algebraic definition: multiplicative inverse then affine map.
    function automatic void build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] x = 8'(a);
            if (a != 0) begin
                inv = 8'h01;
                for (int e = 0; e < 254; e++) inv = gf_mul(inv, x);
            end
            sbox_m[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
    endfunction

    function automatic bit printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7e);
    endfunction

    function automatic void model(input bq_t msg, input int n, input int r, output logic [7:0] dig [32]);
        logic [7:0] h [32];
        bq_t        keys;
        logic [7:0] len = 8'h00;
        for (int i = 0; i < 32; i++) h[i] = IV_T[i % 8];
        foreach (msg[j]) begin
            if (printable(msg[j])) begin
                keys.push_back(msg[j]);
                len = len + 8'h01;
            end
        end
        if (PAD != 0) keys.push_back(len);
        foreach (keys[j]) begin
            for (int rr = 0; rr < r; rr++) begin
                for (int i = 0; i < n; i++) begin
                    h[i] = sbox_m[8'((h[(i + 2) % n] ^ keys[j]) << (i % 8))];
                end
            end
        end
        dig = h;
    endfunction

    function automatic logic [7:0] rand_char();
        if ($urandom_range(0, 4) == 0) return 8'($urandom_range(0, 255));
        return 8'($urandom_range(32, 126));
    endfunction

    task automatic send_a(input logic [7:0] c, input bit last, input bit chk_lat);
        int n;
        int want;
        logic [7:0] d [32];
        bit ok = printable(c);
        cur_msg.push_back(c);
        if (last) begin
            model(cur_msg, NA, RA, d);
            for (int k = 0; k < NA; k++) begin
                exp_q.push_back(d[k]);
                exp_last_q.push_back(k == NA - 1);
            end
            cur_msg.delete();
        end
        if (!ok) err_exp++;
        @(negedge clk);
        a_if.msg_char  = c;
        a_if.msg_valid = 1'b1;
        a_if.msg_last  = last;
        n = 0;
        while (!a_if.msg_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) fail("msg_ready_timeout");
        @(posedge clk);
        #1;
        a_if.msg_valid = 1'b0;
        a_if.msg_last  = 1'b0;
        if (chk_lat) begin
            n = 0;
            if (!last) begin
                want = ok ? RA : 0;
                while (n < 3000) begin
                    @(negedge clk);
                    if (a_if.msg_ready) break;
                    n++;
                end
                check("msg_ready_low_cycles", 32'(n), 32'(want));
            end else begin
                want = ok ? RA * (1 + PAD) : RA * PAD;
                while (n < 3000) begin
                    @(negedge clk);
                    if (a_if.dig_valid) break;
                    n++;
                end
                check("final_latency", 32'(n), 32'(want));
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || a_if.dig_valid) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) fail("drain_timeout");
    endtask

    task automatic send_b(input logic [7:0] c, input bit last, input int want);
        int n = 0;
        @(negedge clk);
        b_if.msg_char  = c;
        b_if.msg_valid = 1'b1;
        b_if.msg_last  = last;
        while (!b_if.msg_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        b_if.msg_valid = 1'b0;
        b_if.msg_last  = 1'b0;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            if (last ? b_if.dig_valid : b_if.msg_ready) break;
            n++;
        end
        check(last ? "b_final_latency" : "b_msg_ready_low", 32'(n), 32'(want));
    endtask

    task automatic read_b(input bq_t msg);
        logic [7:0] d [32];
`ifdef LH_LENGTH_PAD_EN
        model(msg, NB, RB, d);
`else
        d[0] = 8'h2F; d[1] = 8'hAC; d[2] = 8'h6C; d[3] = 8'h45;
        if (msg.size() == 0) d[0] = 8'h00;
`endif
        for (int k = 0; k < NB; k++) begin
            check("b_dig_valid", 32'(b_if.dig_valid), 32'd1);
            check("b_dig_char", 32'(b_if.dig_char), 32'(d[k]));
            check("b_dig_last", 32'(b_if.dig_last), 32'(k == NB - 1));
            @(negedge clk);
        end
        check("b_after_valid", 32'(b_if.dig_valid), 32'd0);
        check("b_after_char", 32'(b_if.dig_char), 32'd0);
        check("b_after_ready", 32'(b_if.msg_ready), 32'd1);
    endtask

    // Digest consumer backpressure: always ready, random, or a 5-cycle stall at byte 3.
    initial begin
        a_if.dig_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (bp_mode == 1) begin
                a_if.dig_ready = ($urandom_range(0, 2) != 0);
            end else if (bp_mode == 2 && out_idx == 3 && hold_left > 0) begin
                a_if.dig_ready = 1'b0;
                hold_left--;
            end else begin
                a_if.dig_ready = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on every accepted digest byte.
    always @(negedge clk) begin
        if (rst) begin
            held    = 1'b0;
            out_idx = 0;
        end else begin
            if (a_if.err_invalid_char) err_seen++;
            if (!a_if.dig_valid) begin
                if (held) fail("dig_valid_dropped_while_stalled");
                held = 1'b0;
                check("idle_dig_char_zero", 32'(a_if.dig_char), 32'd0);
            end else begin
                if (held) check("stalled_dig_char_stable", 32'(a_if.dig_char), 32'(held_char));
                if (!a_if.dig_ready) begin
                    held      = 1'b1;
                    held_char = a_if.dig_char;
                    if (out_idx == 3) hold_cycles++;
                end else begin
                    held = 1'b0;
                    if (exp_q.size() == 0) begin
                        fail("unexpected_digest_byte");
                    end else begin
                        logic [7:0] e;
                        bit         l;
                        e = exp_q.pop_front();
                        l = exp_last_q.pop_front();
                        check("digest_byte", 32'(a_if.dig_char), 32'(e));
                        check("digest_last", 32'(a_if.dig_last), 32'(l));
                        out_idx = l ? 0 : out_idx + 1;
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t bmsg;
        build_sbox();
        a_if.msg_char = 8'h00; a_if.msg_valid = 1'b0; a_if.msg_last = 1'b0;
        b_if.msg_char = 8'h00; b_if.msg_valid = 1'b0; b_if.msg_last = 1'b0;
        b_if.dig_ready = 1'b1;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_msg_ready", 32'(a_if.msg_ready), 32'd0);
        check("rst_dig_valid", 32'(a_if.dig_valid), 32'd0);
        check("rst_dig_char", 32'(a_if.dig_char), 32'd0);
        check("rst_dig_last", 32'(a_if.dig_last), 32'd0);
        check("rst_err", 32'(a_if.err_invalid_char), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_msg_ready", 32'(a_if.msg_ready), 32'd1);

        // Single invalid char with last: IV digest (plus pad rounds when enabled).
        send_a(8'h07, 1'b1, 1'b1);
        drain();
        check("err_pulse_count_single", 32'(err_seen), 32'(err_exp));

        // Small configuration: N=4, ROUNDS=1.
        bmsg = '{8'h41};
        send_b(8'h41, 1'b1, RB * (1 + PAD));
        read_b(bmsg);
        send_b(8'h41, 1'b0, RB);
        bmsg = '{8'h41, 8'h07};
        send_b(8'h07, 1'b1, RB * PAD);
        read_b(bmsg);

        // "abc"
        send_a(8'h61, 1'b0, 1'b1);
        send_a(8'h62, 1'b0, 1'b1);
        send_a(8'h63, 1'b1, 1'b1);
        drain();

        // Stall the consumer for 5 cycles on digest byte 3.
        bp_mode     = 2;
        hold_left   = 5;
        hold_cycles = 0;
        send_a(8'h5a, 1'b0, 1'b1);
        send_a(8'h21, 1'b1, 1'b1);
        drain();
        check("stall_cycles_at_byte3", 32'(hold_cycles), 32'd5);

        // Randomized messages under random backpressure.
        bp_mode = 1;
        for (int m = 0; m < 6; m++) begin
            int len = $urandom_range(1, 4);
            for (int j = 0; j < len; j++) begin
                send_a(rand_char(), (j == len - 1), 1'b1);
            end
            drain();
        end
        bp_mode = 0;

        // Reset during the 10th round cycle discards the partial message.
        send_a(8'h51, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        cur_msg.delete();
        @(negedge clk);
        check("mid_rst_dig_valid", 32'(a_if.dig_valid), 32'd0);
        @(negedge clk);
        check("mid_rst_msg_ready", 32'(a_if.msg_ready), 32'd1);
        send_a(8'h61, 1'b0, 1'b1);
        send_a(8'h62, 1'b0, 1'b1);
        send_a(8'h63, 1'b1, 1'b1);
        drain();

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("err_pulse_count_total", 32'(err_seen), 32'(err_exp));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/light_hash_stream.md
Name: light_hash_stream

Overview:
- Sequential, parametrised successor of the combinational single-shot light hash.
- Absorbs a byte stream through a valid/ready handshake and iterates the AES-S-box round function one round per clock.
- Finalises on a last-marked character and streams the digest out byte by byte with backpressure.
- Sits between the plaintext character source and the digest consumer in the light-hash datapath; reuses the existing AES S-box function.

Parameters:
- DIGEST_BYTES, 8, state/digest length N in bytes; legal range 4..32.
- ROUNDS, 32, rounds applied per absorbed character; legal range 1..255.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- msg_char  in  8  plaintext character.
- msg_valid  in  1  msg_char/msg_last valid.
- msg_last  in  1  final character of message.
- msg_ready  out  1  block can accept a character.
- dig_char  out  8  digest byte.
- dig_valid  out  1  dig_char valid.
- dig_last  out  1  marks digest byte N-1.
- dig_ready  in  1  consumer accepts dig_char.
- err_invalid_char  out  1  one-cycle pulse: rejected character.

Behaviour:
- State H[0..N-1]. IV byte i = {34,55,0F,14,DA,C0,2B,EE}[i mod 8]. H is loaded with the IV on reset and after each digest is fully sent.
- Valid character: 0x20..0x7E. Anything else is invalid.
- Reset (rst=1 at edge): FSM=IDLE, H=IV, round counter=0, msg_ready=0 during reset and 1 the cycle after, dig_char=0x00, dig_valid=0, dig_last=0, err_invalid_char=0. Reset overrides any state mid-round or mid-output; the partial message is discarded.
- FSM states: IDLE, ROUND, OUT.
- IDLE:
  - msg_ready=1. Acceptance = msg_valid & msg_ready.
  - Valid char: latch M=msg_char and the last flag; go to ROUND with counter=0.
  - Invalid char: no state update; err_invalid_char=1 in the next cycle only. If msg_last=1, go to OUT; else stay in IDLE.
- ROUND:
  - msg_ready=0. Each cycle performs one full round.
  - Round definition: for i=0..N-1 in order, in place, H[i] = SBOX(((H[(i+2) mod N] ^ M) << (i mod 8)) truncated to 8 bits). A byte already updated earlier in the same round is read at its new value.
  - Counter increments each cycle. After round ROUNDS-1: if last, go to OUT; else go to IDLE.
  - A single character therefore holds msg_ready low for exactly ROUNDS cycles.
- OUT:
  - dig_valid=1, dig_char=H[k] for k=0..N-1, byte 0 first; dig_last=1 when k=N-1.
  - k advances only when dig_valid & dig_ready. dig_char is held stable while dig_ready=0.
  - After byte N-1 is accepted: H=IV, dig_valid=0, go to IDLE with msg_ready=1 on the next cycle.
- A message made only of invalid characters, ending with last, outputs the IV.
- Outputs are registered. dig_char=0x00 whenever dig_valid=0.
- msg_valid is ignored while msg_ready=0. No character is lost because the source must hold it.

Optional Feature:
- Macro LH_LENGTH_PAD_EN.
- Defined:
  - An 8-bit counter L counts valid characters absorbed since the last IV load, wrapping at 256.
  - On finalisation, before OUT, the block runs one extra ROUND sequence with M=L (ROUNDS more cycles). This applies even when the last character was invalid.
  - L clears with H.
- Undefined: no counter, and finalisation goes directly to OUT.

Test Plan:
- Reset, then a single char 0x07 with last, dig_ready=1 (pad off) -> err_invalid_char pulses once; digest 34 55 0F 14 DA C0 2B EE; dig_last on the 8th byte.
- DIGEST_BYTES=4, ROUNDS=1, single char 0x41 with last -> msg_ready low for 1 cycle; digest 2F AC 6C 45.
- Default parameters, "abc" with last on 'c' -> msg_ready low for 32 cycles after each character; digest matches the bit-exact reference model.
- During OUT, hold dig_ready low for 5 cycles at byte 3 -> dig_char and dig_valid stable; byte order and count unchanged.
- Assert rst during the 10th round cycle -> next cycle IDLE with msg_ready=1; the next message's digest equals a fresh-start digest.
- LH_LENGTH_PAD_EN defined, "abc" -> 4×32 round cycles before OUT; digest matches the model with a pad byte 0x03.
